whirl_tbox_lanes: RTL



---
 rtl/whirl_tbox_lanes_pkg.sv | 49 ++++
 rtl/whirl_c0_rom.sv | 19 +
 rtl/whirl_tbox_lanes.sv | 75 +++++++
 3 files changed

// File: rtl/whirl_tbox_lanes_pkg.sv
// Shared widths and helpers for the Whirlpool T-table lanes: S-box, C0 row, byte rotation.
// Pure combinational functions, no latency of their own.
// No flow control here; the caller's pipeline handles backpressure.
package whirl_tbox_lanes_pkg;

    localparam int WHIRL_W    = 64;
    localparam int WHIRL_BYTE = 8;
    localparam int WHIRL_ROTW = 3;

    // Mini-box tables E, E^-1 and R; entry i sits at nibble [4i+3:4i].
    localparam logic [63:0] MINI_E  = 64'h052A478E3F6DC9B1;
    localparam logic [63:0] MINI_EI = 64'h68431C29A5EB7D0F;
    localparam logic [63:0] MINI_R  = 64'h0152A836F94EDBC7;

    function automatic logic [3:0] nib(input logic [63:0] tab, input logic [3:0] x);
        return tab[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [WHIRL_BYTE-1:0] sbox(input logic [WHIRL_BYTE-1:0] x);
        logic [3:0] a, b, r;
        a = nib(MINI_E, x[7:4]);
        b = nib(MINI_EI, x[3:0]);
        r = nib(MINI_R, a ^ b);
        return {nib(MINI_E, a ^ r), nib(MINI_EI, b ^ r)};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [WHIRL_BYTE-1:0] xtime(input logic [WHIRL_BYTE-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1d : 8'h00);
    endfunction

    // C0 row: S[x] times the circulant coefficients 1,1,4,1,8,5,2,9, MSB first.
    function automatic logic [WHIRL_W-1:0] c0_entry(input logic [WHIRL_BYTE-1:0] x);
        logic [WHIRL_BYTE-1:0] s1, s2, s4, s8;
        s1 = sbox(x);
        s2 = xtime(s1);
        s4 = xtime(s2);
        s8 = xtime(s4);
        return {s1, s1, s4, s1, s8, s4 ^ s1, s2, s8 ^ s1};
    endfunction

    function automatic logic [WHIRL_W-1:0] rotr64(input logic [WHIRL_W-1:0] x,
                                                   input logic [WHIRL_ROTW-1:0] r);
        logic [2*WHIRL_W-1:0] d;
        d = {x, x} >> (r * WHIRL_BYTE);
        return d[WHIRL_W-1:0];
    endfunction

endpackage

// File: rtl/whirl_c0_rom.sv
// 256x64 Whirlpool C0 table with a registered, clock-enabled output.
// Latency 1 cycle; output holds whenever i_en is low.
// No handshake; the enclosing pipeline drives i_en from its advance enable.
module whirl_c0_rom
    import whirl_tbox_lanes_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic [WHIRL_BYTE-1:0] i_addr,
    output logic [WHIRL_W-1:0]    o_data
);

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            o_data <= c0_entry(i_addr);
        end
    end

endmodule

// File: rtl/whirl_tbox_lanes.sv
// NLANES-wide Whirlpool T-table lookup: rotated C0 per lane plus optional XOR of all lanes.
// Latency 2 cycles accept-to-o_valid, one beat per cycle.
// Whole pipeline freezes while o_valid=1 and i_ready=0; o_ready mirrors the advance enable.
module whirl_tbox_lanes
    import whirl_tbox_lanes_pkg::*;
#(
    parameter int NLANES = 8,
    parameter int DLY    = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [WHIRL_BYTE*NLANES-1:0]   i_addr,
    input  logic [WHIRL_ROTW*NLANES-1:0]   i_rot,
    input  logic                           i_xor,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [WHIRL_W*NLANES-1:0]      o_data,
    output logic [WHIRL_W-1:0]             o_xor
);

    if (NLANES < 1 || NLANES > 8 || DLY < 0) begin : g_bad_param
        $error("whirl_tbox_lanes: NLANES must be 1..8 and DLY non-negative");
    end

    logic                         en;
    logic                         s1_valid;
    logic [WHIRL_ROTW*NLANES-1:0] s1_rot;
    logic                         s1_xor;
    logic [WHIRL_W-1:0]           rom_q [NLANES];
    logic [WHIRL_W*NLANES-1:0]    lane_nxt;
    logic [WHIRL_W-1:0]           xor_nxt;

    assign en      = ~o_valid | i_ready;
    assign o_ready = en;

    // ROM output register is stage 1 data; it shares the advance enable so stalls hold it.
    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        whirl_c0_rom u_rom (
            .i_clk  (i_clk),
            .i_en   (en),
            .i_addr (i_addr[WHIRL_BYTE*g +: WHIRL_BYTE]),
            .o_data (rom_q[g])
        );
    end

    always_comb begin
        lane_nxt = '0;
        xor_nxt  = '0;
        for (int k = 0; k < NLANES; k++) begin
            lane_nxt[WHIRL_W*k +: WHIRL_W] = rotr64(rom_q[k], s1_rot[WHIRL_ROTW*k +: WHIRL_ROTW]);
            xor_nxt = xor_nxt ^ lane_nxt[WHIRL_W*k +: WHIRL_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_rot   <= '0;
            s1_xor   <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_xor    <= '0;
        end else if (en) begin
            s1_valid <= i_valid;
            s1_rot   <= i_rot;
            s1_xor   <= i_xor;
            o_valid  <= s1_valid;
            o_data   <= lane_nxt;
            o_xor    <= s1_xor ? xor_nxt : '0;
        end
    end

endmodule
